// File: rtl/operand_holder.sv
// operand_holder: captures a WIDTH-bit operand into one of SLOTS registers
// once the input has held the same value for STABLE_CYCLES consecutive edges
// while LOAD is commanded. Supports per-slot CLEAR and presents the addressed
// slot plus its valid flag combinationally.
//
// Optional feature macro: OPERAND_HOLDER_CLEAR_ALL_EN
//   defined     -> Sel == 3'b111 clears every slot and returns the FSM to IDLE
//   not defined -> Sel == 3'b111 is treated as HOLD, no bulk-clear logic
module operand_holder #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 2,
  parameter int SLOTS         = 2,
  localparam int SLOT_W       = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  A,
  input  logic [2:0]        Sel,
  input  logic [SLOT_W-1:0] slot,
  output logic [WIDTH-1:0]  Out,
  output logic              out_valid,
  output logic              loaded,
  output logic              busy
);

  // Command encodings
  localparam logic [2:0] CMD_LOAD  = 3'b010;
  localparam logic [2:0] CMD_CLEAR = 3'b100;

  // FSM encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // The run counter saturates at STABLE_CYCLES-1 (at most 254), so 8 bits
  // always suffice for the legal parameter range.
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] CNT_ARM = 8'(STABLE_CYCLES - 2);

  // Slot count expressed one bit wider than the index, so the range test
  // also works when SLOTS is an exact power of two.
  localparam logic [SLOT_W:0] SLOT_LIMIT = (SLOT_W + 1)'(SLOTS);

  // Stability tracker state
  logic [WIDTH-1:0] samp_q;
  logic [7:0]       cnt_q;
  logic [7:0]       cnt_d;
  logic             same_sample;
  logic             stable;

  // Control state
  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       loaded_q;

  // Decoded commands and per-edge actions
  logic cmd_load;
  logic cmd_clear;
  logic cmd_clear_all;
  logic do_capture;
  logic do_clear_one;
  logic do_clear_all;

  // Slot addressing and storage views
  logic                  slot_in_range;
  logic [SLOTS-1:0]      slot_hit;
  logic [WIDTH-1:0]      slot_data [SLOTS];
  logic [SLOTS-1:0]      slot_valid;
  logic [WIDTH-1:0]      out_mux;
  logic                  valid_mux;

  assign cmd_load  = (Sel == CMD_LOAD);
  assign cmd_clear = (Sel == CMD_CLEAR);

`ifdef OPERAND_HOLDER_CLEAR_ALL_EN
  assign cmd_clear_all = (Sel == 3'b111);
`else
  assign cmd_clear_all = 1'b0;
`endif

  assign slot_in_range = ({1'b0, slot} < SLOT_LIMIT);

  // A counts as stable when this edge's sample matches the previous one and
  // enough earlier matches have accumulated: STABLE_CYCLES equal samples in
  // total, including the current edge.
  assign same_sample = (A == samp_q);
  assign stable      = same_sample && (cnt_q >= CNT_ARM);

  // Next run-length count: saturating increment on a repeat, restart on change
  always_comb begin
    cnt_d = 8'd0;
    if (same_sample) begin
      cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : (cnt_q + 8'd1);
    end
  end

  // Stability tracker registers, updated on every edge regardless of Sel
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      samp_q <= '0;
      cnt_q  <= 8'd0;
    end else begin
      samp_q <= A;
      cnt_q  <= cnt_d;
    end
  end

  // Command sequencing: clears override everything, otherwise at most one
  // capture per continuous LOAD assertion.
  always_comb begin
    state_d      = state_q;
    do_capture   = 1'b0;
    do_clear_one = 1'b0;
    do_clear_all = 1'b0;
    if (cmd_clear_all) begin
      do_clear_all = 1'b1;
      state_d      = ST_IDLE;
    end else if (cmd_clear) begin
      do_clear_one = 1'b1;
      state_d      = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_load) begin
            if (stable) begin
              do_capture = 1'b1;
              state_d    = ST_DONE;
            end else begin
              state_d    = ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          if (cmd_load) begin
            if (stable) begin
              do_capture = 1'b1;
              state_d    = ST_DONE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DONE: begin
          if (!cmd_load) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state and the one-cycle capture pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      loaded_q <= do_capture;
    end
  end

  // One operand register and valid flag per slot
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    assign slot_hit[gi]   = slot_in_range && (slot == SLOT_W'(gi));
    assign slot_data[gi]  = data_q;
    assign slot_valid[gi] = valid_q;

    // Clear wins over capture; only the addressed slot is touched
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (do_clear_all || (do_clear_one && slot_hit[gi])) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (do_capture && slot_hit[gi]) begin
        data_q  <= A;
        valid_q <= 1'b1;
      end
    end
  end

  // Read mux: an out-of-range address reads as empty
  always_comb begin
    out_mux   = '0;
    valid_mux = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (slot_hit[i]) begin
        out_mux   = slot_data[i];
        valid_mux = slot_valid[i];
      end
    end
  end

  assign Out       = out_mux;
  assign out_valid = valid_mux;
  assign loaded    = loaded_q;
  assign busy      = (state_q == ST_ARMED);

endmodule

// File: tb/tb_operand_holder.sv
// Testbench for operand_holder. Two instances share A/Sel:
//   u_a: WIDTH=8, STABLE_CYCLES=2, SLOTS=2 (slot index = slot_s[0])
//   u_b: WIDTH=8, STABLE_CYCLES=4, SLOTS=3 (slot index = slot_s, 3 is out of range)
// A run-length/flag model predicts every output each cycle; directed
// literal checks pin the model for the main scenarios.
module tb_operand_holder;

  localparam logic [2:0] HOLD  = 3'b000;
  localparam logic [2:0] LOAD  = 3'b010;
  localparam logic [2:0] CLEAR = 3'b100;
  localparam logic [2:0] CALL  = 3'b111;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] A;
  logic [2:0] Sel;
  logic [1:0] slot_s;

  logic [7:0] out_a, out_b;
  logic       val_a, val_b, ld_a, ld_b, busy_a, busy_b;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  always #5 clock = ~clock;

  operand_holder #(.WIDTH(8), .STABLE_CYCLES(2), .SLOTS(2)) u_a (
    .clock(clock), .reset_n(reset_n), .A(A), .Sel(Sel), .slot(slot_s[0]),
    .Out(out_a), .out_valid(val_a), .loaded(ld_a), .busy(busy_a)
  );

  operand_holder #(.WIDTH(8), .STABLE_CYCLES(4), .SLOTS(3)) u_b (
    .clock(clock), .reset_n(reset_n), .A(A), .Sel(Sel), .slot(slot_s),
    .Out(out_b), .out_valid(val_b), .loaded(ld_b), .busy(busy_b)
  );

  // ---------------- behavioural model ----------------
  int         sc     [2] = '{2, 4};
  int         nslots [2] = '{2, 3};
  int         m_run  [2];
  logic [7:0] m_last [2];
  bit         m_wait [2];   // LOAD seen, still waiting for a stable input
  bit         m_used [2];   // current LOAD assertion already produced its capture
  bit         m_ld   [2];
  logic [7:0] m_mem  [2][3];
  bit         m_val  [2][3];

  function automatic int idx_of(int k);
    return (k == 0) ? int'(slot_s[0]) : int'(slot_s);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 1; m_last[k] = 8'h00;
      m_wait[k] = 0; m_used[k] = 0; m_ld[k] = 0;
      for (int s = 0; s < 3; s++) begin
        m_mem[k][s] = 8'h00; m_val[k][s] = 0;
      end
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int i;
      bit inr, stable, clr_all;
      i = idx_of(k);
      inr = (i < nslots[k]);
      // How many consecutive edges (including this one) has A held its value?
      if (A == m_last[k]) m_run[k] = (m_run[k] < 1000) ? m_run[k] + 1 : 1000;
      else m_run[k] = 1;
      m_last[k] = A;
      stable = (m_run[k] >= sc[k]);
`ifdef OPERAND_HOLDER_CLEAR_ALL_EN
      clr_all = (Sel == CALL);
`else
      clr_all = 0;
`endif
      m_ld[k] = 0;
      if (clr_all) begin
        for (int s = 0; s < 3; s++) begin m_mem[k][s] = 8'h00; m_val[k][s] = 0; end
        m_wait[k] = 0; m_used[k] = 0;
      end else if (Sel == CLEAR) begin
        if (inr) begin m_mem[k][i] = 8'h00; m_val[k][i] = 0; end
        m_wait[k] = 0; m_used[k] = 0;
      end else if (Sel == LOAD) begin
        if (!m_used[k]) begin
          if (stable) begin
            m_ld[k] = 1; m_used[k] = 1; m_wait[k] = 0;
            if (inr) begin m_mem[k][i] = A; m_val[k][i] = 1; end
          end else begin
            m_wait[k] = 1;
          end
        end
      end else begin
        m_wait[k] = 0; m_used[k] = 0;
      end
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  function automatic logic [7:0] exp_out(int k);
    int i;
    i = idx_of(k);
    return (i < nslots[k]) ? m_mem[k][i] : 8'h00;
  endfunction

  function automatic bit exp_val(int k);
    int i;
    i = idx_of(k);
    return (i < nslots[k]) ? m_val[k][i] : 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("a.Out",       32'(out_a),  32'(exp_out(0)));
      chk("a.out_valid", 32'(val_a),  32'(exp_val(0)));
      chk("a.loaded",    32'(ld_a),   32'(m_ld[0]));
      chk("a.busy",      32'(busy_a), 32'(m_wait[0]));
      chk("b.Out",       32'(out_b),  32'(exp_out(1)));
      chk("b.out_valid", 32'(val_b),  32'(exp_val(1)));
      chk("b.loaded",    32'(ld_b),   32'(m_ld[1]));
      chk("b.busy",      32'(busy_b), 32'(m_wait[1]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [2:0] s, input logic [7:0] a, input logic [1:0] sl);
    Sel = s; A = a; slot_s = sl;
    @(posedge clock);
    #1;
    $display("step t=%0t Sel=%b A=%02h slot=%0d | a: Out=%02h v=%b ld=%b busy=%b | b: Out=%02h v=%b ld=%b busy=%b",
             $time, s, a, sl, out_a, val_a, ld_a, busy_a, out_b, val_b, ld_b, busy_b);
  endtask

  // Hold A for two HOLD edges, then LOAD once, then release with HOLD
  task automatic load_slot(input logic [7:0] a, input logic [1:0] sl);
    step(HOLD, a, sl);
    step(HOLD, a, sl);
    step(LOAD, a, sl);
    step(HOLD, a, sl);
  endtask

  initial begin
    int pulses_a;
    int pulses_b;
    reset_n = 1'b1; A = 8'h00; Sel = HOLD; slot_s = 2'd0;
    #1 reset_n = 1'b0;
    cmp_en = 1;
    #1;
    chk("reset.Out",    32'(out_a),  32'h0);
    chk("reset.valid",  32'(val_a),  32'h0);
    chk("reset.busy",   32'(busy_a), 32'h0);
    chk("reset.loaded", 32'(ld_a),   32'h0);
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;

    // Stable load: A held before LOAD -> capture on the first LOAD edge
    step(HOLD, 8'h37, 2'd0);
    step(HOLD, 8'h37, 2'd0);
    step(HOLD, 8'h37, 2'd0);
    step(LOAD, 8'h37, 2'd0);
    chk("stable.loaded", 32'(ld_a),  32'h1);
    chk("stable.Out",    32'(out_a), 32'h37);
    chk("stable.valid",  32'(val_a), 32'h1);
    chk("stable.b_loaded", 32'(ld_b), 32'h1);
    pulses_a = 0;
    for (int n = 0; n < 10; n++) begin
      step(LOAD, 8'h37, 2'd0);
      if (ld_a) pulses_a++;
    end
    chk("held_load.extra_pulses", 32'(pulses_a), 32'h0);
    step(HOLD, 8'h37, 2'd0);

    // Unstable input: alternating A keeps the block armed with no capture
    pulses_a = 0;
    for (int n = 0; n < 5; n++) begin
      step(LOAD, (n % 2 == 0) ? 8'h11 : 8'h22, 2'd0);
      if (ld_a) pulses_a++;
    end
    chk("unstable.busy",   32'(busy_a),   32'h1);
    chk("unstable.pulses", 32'(pulses_a), 32'h0);
    step(LOAD, 8'h22, 2'd0);
    chk("hold_first.loaded", 32'(ld_a),   32'h0);
    chk("hold_first.busy",   32'(busy_a), 32'h1);
    step(LOAD, 8'h22, 2'd0);
    chk("hold_second.loaded", 32'(ld_a),  32'h1);
    chk("hold_second.Out",    32'(out_a), 32'h22);
    step(HOLD, 8'h22, 2'd0);

    // Multi-slot
    load_slot(8'h0F, 2'd0);
    load_slot(8'hF0, 2'd1);
    slot_s = 2'd0; #1;
    chk("multi.slot0", 32'(out_a), 32'h0F);
    slot_s = 2'd1; #1;
    chk("multi.slot1", 32'(out_a), 32'hF0);
    step(CLEAR, 8'hF0, 2'd1);
    chk("clear1.Out",   32'(out_a), 32'h0);
    chk("clear1.valid", 32'(val_a), 32'h0);
    slot_s = 2'd0; #1;
    chk("clear1.slot0_kept", 32'(out_a), 32'h0F);
    chk("clear1.slot0_valid", 32'(val_a), 32'h1);

    // CLEAR while armed: no capture anywhere, slot zeroed, back to idle
    pulses_a = 0; pulses_b = 0;
    step(LOAD, 8'h01, 2'd0); if (ld_a) pulses_a++; if (ld_b) pulses_b++;
    step(LOAD, 8'h02, 2'd0); if (ld_a) pulses_a++; if (ld_b) pulses_b++;
    chk("armed.busy_a", 32'(busy_a), 32'h1);
    chk("armed.busy_b", 32'(busy_b), 32'h1);
    step(CLEAR, 8'h03, 2'd0); if (ld_a) pulses_a++; if (ld_b) pulses_b++;
    step(HOLD, 8'h03, 2'd0);  if (ld_a) pulses_a++; if (ld_b) pulses_b++;
    chk("armclr.Out",    32'(out_a),    32'h0);
    chk("armclr.valid",  32'(val_a),    32'h0);
    chk("armclr.busy_b", 32'(busy_b),   32'h0);
    chk("armclr.pulses_a", 32'(pulses_a), 32'h0);
    chk("armclr.pulses_b", 32'(pulses_b), 32'h0);

    // Out-of-range slot on the 3-slot instance: sequencing continues, storage untouched
    step(HOLD, 8'h99, 2'd3);
    step(HOLD, 8'h99, 2'd3);
    step(HOLD, 8'h99, 2'd3);
    step(LOAD, 8'h99, 2'd3);
    chk("oor.b_Out",   32'(out_b), 32'h0);
    chk("oor.b_valid", 32'(val_b), 32'h0);
    step(HOLD, 8'h99, 2'd2);
    step(LOAD, 8'h99, 2'd2);
    chk("slot2.b_Out", 32'(out_b), 32'h99);
    step(HOLD, 8'h99, 2'd2);

    // Bulk clear (or HOLD when the feature is absent)
    load_slot(8'hAA, 2'd0);
    load_slot(8'h55, 2'd1);
    step(CALL, 8'h55, 2'd0);
`ifdef OPERAND_HOLDER_CLEAR_ALL_EN
    chk("call.slot0", 32'(out_a), 32'h0);
    chk("call.valid0", 32'(val_a), 32'h0);
    slot_s = 2'd1; #1;
    chk("call.slot1", 32'(out_a), 32'h0);
`else
    chk("call.slot0", 32'(out_a), 32'hAA);
    chk("call.valid0", 32'(val_a), 32'h1);
    slot_s = 2'd1; #1;
    chk("call.slot1", 32'(out_a), 32'h55);
`endif
    step(HOLD, 8'h55, 2'd0);

    // Asynchronous reset in the middle of an armed load
    load_slot(8'h5A, 2'd0);
    chk("pre_reset.Out", 32'(out_a), 32'h5A);
    step(LOAD, 8'h01, 2'd0);
    step(LOAD, 8'h02, 2'd0);
    chk("pre_reset.busy", 32'(busy_a), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("async_reset.Out",    32'(out_a),  32'h0);
    chk("async_reset.valid",  32'(val_a),  32'h0);
    chk("async_reset.busy",   32'(busy_a), 32'h0);
    chk("async_reset.loaded", 32'(ld_a),   32'h0);
    #2 reset_n = 1'b1;
    step(HOLD, 8'h02, 2'd0);
    chk("post_reset.busy", 32'(busy_a), 32'h0);
    chk("post_reset.Out",  32'(out_a),  32'h0);
    step(HOLD, 8'h02, 2'd0);

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
